button_event_arbiter: RTL and testbench

Converts per-button level signals from the debouncer into discrete press and auto-repeat events, and delivers them one at a time to a single consumer over a valid/ready handshake. Sits directly downstream of `debouncer` (its `debounced_signal` bus feeds `buttons_in`) and upstream of whatever FSM consumes user input. Pending events are latched per channel and shared fairly with a round-robin arbiter, so no button starves another.

---
 rtl/button_event_arbiter.sv | 89 ++++++++
 tb/tb_button_event_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: turns debounced button levels into press/auto-repeat events
// and hands them to one consumer over valid/ready with round-robin fairness.
module button_event_arbiter #(
    parameter int WIDTH          = 4,
    parameter int HOLD_CNT_MAX   = 25000000,
    parameter int REPEAT_CNT_MAX = 6250000,
    parameter int ID_W           = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] buttons_in,
    output logic             event_valid,
    output logic [ID_W-1:0]  event_id,
    output logic             event_repeat,
    input  logic             event_ready,
    output logic [WIDTH-1:0] pending
);
    localparam int CNT_MAX = HOLD_CNT_MAX > REPEAT_CNT_MAX ? HOLD_CNT_MAX : REPEAT_CNT_MAX;
    localparam int CNT_W   = $clog2(CNT_MAX);

    typedef enum logic {IDLE, VALID} state_t;
    state_t state_q, state_d;

    logic [WIDTH-1:0]            btn_prev_q, phase_q, phase_d, pend_q, pend_d, pend_rep_q, pend_rep_d;
    logic [WIDTH-1:0]            rise, hit, set, clr;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]             id_q, id_d, rr_q, rr_d, gnt_id;
    logic                        rep_q, rep_d, grant;

    always_comb begin
        rise = buttons_in & ~btn_prev_q;
        hit  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            hit[i]     = buttons_in[i] && !rise[i] &&
                         cnt_q[i] == (phase_q[i] ? CNT_W'(REPEAT_CNT_MAX - 1) : CNT_W'(HOLD_CNT_MAX - 1));
            cnt_d[i]   = (buttons_in[i] && !rise[i] && !hit[i]) ? cnt_q[i] + 1'b1 : '0;
            phase_d[i] = buttons_in[i] && !rise[i] && (hit[i] || phase_q[i]);
        end
    end

    // Reverse scan so the nearest channel after rr_q is the last one written.
    always_comb begin
        gnt_id = '0;
        for (int k = WIDTH; k >= 1; k--)
            if (pend_q[ID_W'((int'(rr_q) + k) % WIDTH)]) gnt_id = ID_W'((int'(rr_q) + k) % WIDTH);
    end

    // A new event on a channel being granted this cycle is kept, not dropped.
    always_comb begin
        grant      = |pend_q && (state_q == IDLE || event_ready);
        clr        = grant ? WIDTH'(1) << gnt_id : '0;
        set        = (rise | hit) & (~pend_q | clr);
        pend_d     = (pend_q & ~clr) | set;
        pend_rep_d = (pend_rep_q & ~set) | (hit & set);
        state_d    = grant ? VALID : (event_ready ? IDLE : state_q);
        id_d       = grant ? gnt_id : id_q;
        rep_d      = grant ? pend_rep_q[gnt_id] : rep_q;
        rr_d       = grant ? gnt_id : rr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            btn_prev_q <= '0;
            phase_q    <= '0;
            cnt_q      <= '0;
            pend_q     <= '0;
            pend_rep_q <= '0;
            id_q       <= '0;
            rep_q      <= 1'b0;
            rr_q       <= ID_W'(WIDTH - 1);
        end else begin
            state_q    <= state_d;
            btn_prev_q <= buttons_in;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_rep_q <= pend_rep_d;
            id_q       <= id_d;
            rep_q      <= rep_d;
            rr_q       <= rr_d;
        end
    end

    assign event_valid  = state_q == VALID;
    assign event_id     = id_q;
    assign event_repeat = rep_q;
    assign pending      = pend_q;
endmodule

// File: tb/tb_button_event_arbiter.sv
// tb_button_event_arbiter: directed steps with a scoreboard of expected events,
// each event tagged with the cycle at which its handshake must occur.
module tb_button_event_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] buttons_in = 4'b1111;
    logic       event_ready = 1'b1;
    logic       event_valid;
    logic [1:0] event_id;
    logic       event_repeat;
    logic [3:0] pending;

    typedef struct {int id; int rep; int at;} ev_t;
    ev_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc_n = 0;

    button_event_arbiter #(.WIDTH(4), .HOLD_CNT_MAX(20), .REPEAT_CNT_MAX(8)) dut (
        .clk(clk), .rst_n(rst_n), .buttons_in(buttons_in), .event_valid(event_valid),
        .event_id(event_id), .event_repeat(event_repeat), .event_ready(event_ready), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic push(input int id, input int rep, input int at);
        ev_t e;
        e.id = id; e.rep = rep; e.at = at;
        sb.push_back(e);
    endtask

    // Called at a negedge after inputs are driven: a visible valid&ready is consumed at the next posedge.
    task automatic cyc();
        ev_t e;
        if (event_valid === 1'b1 && event_ready) begin
            chk("event_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("event_id", 32'(event_id), e.id);
                chk("event_repeat", 32'(event_repeat), e.rep);
                chk("event_cycle", cyc_n, e.at);
            end
        end
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        int k;
        // reset with all buttons held
        run(3);
        chk("rst_valid", 32'(event_valid), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_id", 32'(event_id), 0);
        chk("rst_repeat", 32'(event_repeat), 0);
        rst_n = 1'b1;
        k = cyc_n;
        for (int i = 0; i < 4; i++) push(i, 0, k + 2 + i);
        run(5);
        buttons_in = 4'b0000;
        run(6);
        // single press on channel 2
        k = cyc_n;
        buttons_in = 4'b0100;
        push(2, 0, k + 2);
        run(10);
        buttons_in = 4'b0000;
        run(5);
        // channel 3 press leaves rr pointer at 3
        k = cyc_n;
        buttons_in = 4'b1000;
        push(3, 0, k + 2);
        run(3);
        buttons_in = 4'b0000;
        run(5);
        // contention with consumer stalled
        event_ready = 1'b0;
        k = cyc_n;
        buttons_in = 4'b1011;
        run(3);
        buttons_in = 4'b0000;
        for (int i = 0; i < 7; i++) begin
            chk("stall_valid", 32'(event_valid), 1);
            chk("stall_id", 32'(event_id), 0);
            cyc();
        end
        event_ready = 1'b1;
        push(0, 0, k + 10);
        push(1, 0, k + 11);
        push(3, 0, k + 12);
        run(3);
        chk("contention_idle", 32'(event_valid), 0);
        run(3);
        // auto-repeat on channel 1
        k = cyc_n;
        buttons_in = 4'b0010;
        push(1, 0, k + 2);
        push(1, 1, k + 22);
        push(1, 1, k + 30);
        push(1, 1, k + 38);
        push(1, 1, k + 46);
        run(50);
        buttons_in = 4'b0000;
        run(12);
        // coalescing: third pulse dropped
        event_ready = 1'b0;
        k = cyc_n;
        for (int p = 0; p < 3; p++) begin
            buttons_in = 4'b0001;
            run(2);
            buttons_in = 4'b0000;
            run(2);
        end
        event_ready = 1'b1;
        push(0, 0, k + 12);
        push(0, 0, k + 13);
        run(2);
        chk("coalesce_idle", 32'(event_valid), 0);
        run(4);
        // asynchronous reset mid-handshake
        event_ready = 1'b0;
        buttons_in = 4'b1000;
        run(1);
        buttons_in = 4'b0110;
        run(1);
        buttons_in = 4'b0000;
        chk("pre_rst_valid", 32'(event_valid), 1);
        chk("pre_rst_id", 32'(event_id), 3);
        chk("pre_rst_pending", 32'(pending), 32'b0110);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(event_valid), 0);
        chk("async_rst_pending", 32'(pending), 0);
        chk("async_rst_id", 32'(event_id), 0);
        @(negedge clk);
        rst_n = 1'b1;
        event_ready = 1'b1;
        run(5);
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
